game_sequencer: RTL and testbench

//  Top-level game-flow controller. Sequences title, play, respawn, level-won and game-over phases.

---
 rtl/game_sequencer_pkg.sv | 62 ++++++
 rtl/game_sequencer_if.sv | 37 +++
 rtl/game_sequencer_frame_timer.sv | 41 ++++
 rtl/game_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// game_sequencer_pkg
// Shared types for the game-flow controller: FSM state encoding (also exported
// on the debug LEDs), screen selection codes for the pixel-colour mux, field
// widths, and the per-state output decode used when a state is entered.
// No ports (package).
// -----------------------------------------------------------------------------
package game_sequencer_pkg;

    localparam int LIVES_W = 3;
    localparam int LEVEL_W = 4;

    typedef enum logic [2:0] {
        ST_TITLE  = 3'd0,
        ST_START  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_HIT    = 3'd3,
        ST_WIN    = 3'd4,
        ST_LOSE   = 3'd5,
        ST_PAUSED = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SCR_TITLE = 2'd0,
        SCR_PLAY  = 2'd1,
        SCR_WIN   = 2'd2,
        SCR_LOSE  = 2'd3
    } screen_e;

    typedef struct packed {
        logic    game_reset;
        logic    run;
        screen_e screen;
    } outs_t;

    // Output levels that hold for the whole time a state is occupied.
    function automatic outs_t state_outs(state_e s);
        outs_t o;
        o = '{game_reset: 1'b0, run: 1'b0, screen: SCR_PLAY};
        case (s)
            ST_TITLE:  o = '{game_reset: 1'b1, run: 1'b0, screen: SCR_TITLE};
            ST_START:  o = '{game_reset: 1'b1, run: 1'b0, screen: SCR_PLAY};
            ST_PLAY:   o = '{game_reset: 1'b0, run: 1'b1, screen: SCR_PLAY};
            ST_HIT:    o = '{game_reset: 1'b0, run: 1'b0, screen: SCR_PLAY};
            ST_WIN:    o = '{game_reset: 1'b0, run: 1'b0, screen: SCR_WIN};
            ST_LOSE:   o = '{game_reset: 1'b0, run: 1'b0, screen: SCR_LOSE};
            ST_PAUSED: o = '{game_reset: 1'b0, run: 1'b0, screen: SCR_PLAY};
            default:   o = '{game_reset: 1'b1, run: 1'b0, screen: SCR_TITLE};
        endcase
        return o;
    endfunction

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_sequencer_if
// Bundles the game-flow controller's event inputs and control/status outputs.
//   master modport : the sequencer (reads events, drives controls)
//   slave modport  : the surrounding game logic (drives events, reads controls)
// Signals:
//   frame_i, shoot_i, pause_i, player_hit_i, enemies_landed_i, enemies_dead_i
//   game_reset_o, run_o, add_life_o, screen_o[1:0], lives_o[2:0],
//   level_o[3:0], state_o[2:0]
// -----------------------------------------------------------------------------
interface game_sequencer_if;

    logic                                  frame_i;
    logic                                  shoot_i;
    logic                                  pause_i;
    logic                                  player_hit_i;
    logic                                  enemies_landed_i;
    logic                                  enemies_dead_i;
    logic                                  game_reset_o;
    logic                                  run_o;
    logic                                  add_life_o;
    logic [1:0]                            screen_o;
    logic [game_sequencer_pkg::LIVES_W-1:0] lives_o;
    logic [game_sequencer_pkg::LEVEL_W-1:0] level_o;
    logic [2:0]                            state_o;

    modport master (
        input  frame_i, shoot_i, pause_i, player_hit_i, enemies_landed_i, enemies_dead_i,
        output game_reset_o, run_o, add_life_o, screen_o, lives_o, level_o, state_o
    );

    modport slave (
        output frame_i, shoot_i, pause_i, player_hit_i, enemies_landed_i, enemies_dead_i,
        input  game_reset_o, run_o, add_life_o, screen_o, lives_o, level_o, state_o
    );

endinterface

// File: rtl/game_sequencer_frame_timer.sv
// -----------------------------------------------------------------------------
// game_sequencer_frame_timer
// Saturating frame-pulse counter shared by all timed states.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : first cycle of a new state; the count is treated as zero
//                this cycle so a frame arriving now is already counted
//   frame      : count enable (one pulse per frame)
//   target     : number of frames to wait for in the current state
//   done       : this frame completes the target count
//   elapsed    : target count already reached in an earlier frame
// -----------------------------------------------------------------------------
module game_sequencer_frame_timer #(
    parameter int WIDTH_P = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               frame,
    input  logic [WIDTH_P-1:0] target,
    output logic               done,
    output logic               elapsed
);

    logic [WIDTH_P-1:0] cnt;
    logic [WIDTH_P-1:0] cnt_eff;

    assign cnt_eff = clr ? '0 : cnt;
    assign done    = frame && (cnt_eff == (target - WIDTH_P'(1)));
    assign elapsed = (cnt_eff >= target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (frame && (cnt_eff != '1)) begin
            cnt <= cnt_eff + WIDTH_P'(1);
        end else begin
            cnt <= cnt_eff;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Game-flow controller in the 25 MHz pixel domain: sequences title, start,
// play, respawn (HIT), level-won and game-over phases; all delays are counted
// in frame pulses. Outputs are registered and change on the edge a state is
// entered.
// Ports:
//   clk_i                  : pixel clock
//   reset_n_async_unsafe_i : asynchronous active-low reset
//   bus (master)           : event inputs and control/status outputs, see
//                            game_sequencer_if
// Optional feature: define GAME_PAUSE_EN to enable the PAUSED state toggled by
// rising edges of pause_i while playing. Without it pause_i is unused.
// -----------------------------------------------------------------------------
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int START_FRAMES_P = 30,
    parameter int HIT_FRAMES_P   = 60,
    parameter int WIN_FRAMES_P   = 120,
    parameter int LOSE_FRAMES_P  = 60,
    parameter int INIT_LIVES_P   = 3,
    parameter int MAX_LIVES_P    = 5
) (
    input  logic             clk_i,
    input  logic             reset_n_async_unsafe_i,
    game_sequencer_if.master bus
);

    localparam int FCNT_W = $clog2(max4(START_FRAMES_P, HIT_FRAMES_P,
                                        WIN_FRAMES_P, LOSE_FRAMES_P) + 1);

    state_e               state;
    outs_t                outs;
    logic                 add_life;
    logic [LIVES_W-1:0]   lives;
    logic [LEVEL_W-1:0]   level;
    logic                 shoot_q;
    logic                 shoot_rise;
    logic                 pause_rise;
    logic                 fcnt_clr;
    logic                 frame_cnt;
    logic [FCNT_W-1:0]    target;
    logic                 t_done;
    logic                 t_elapsed;

    // shoot_q resets high so a button held through reset never counts as a press.
    assign shoot_rise = bus.shoot_i & ~shoot_q;

`ifdef GAME_PAUSE_EN
    logic pause_q;

    assign pause_rise = bus.pause_i & ~pause_q;

    always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
        if (!reset_n_async_unsafe_i) begin
            pause_q <= 1'b1;
        end else begin
            pause_q <= bus.pause_i;
        end
    end
`else
    logic unused_pause;

    assign unused_pause = bus.pause_i;
    assign pause_rise   = 1'b0;
`endif

    // The frame count is frozen while paused.
    assign frame_cnt = bus.frame_i & (state != ST_PAUSED);

    always_comb begin
        target = '0;
        case (state)
            ST_START: target = FCNT_W'(START_FRAMES_P);
            ST_HIT:   target = FCNT_W'(HIT_FRAMES_P);
            ST_WIN:   target = FCNT_W'(WIN_FRAMES_P);
            ST_LOSE:  target = FCNT_W'(LOSE_FRAMES_P);
            default:  target = '0;
        endcase
    end

    game_sequencer_frame_timer #(
        .WIDTH_P (FCNT_W)
    ) u_timer (
        .clk     (clk_i),
        .rst_n   (reset_n_async_unsafe_i),
        .clr     (fcnt_clr),
        .frame   (frame_cnt),
        .target  (target),
        .done    (t_done),
        .elapsed (t_elapsed)
    );

    // Every transition loads the new state's outputs and restarts the frame count.
    always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
        if (!reset_n_async_unsafe_i) begin
            state    <= ST_TITLE;
            outs     <= state_outs(ST_TITLE);
            add_life <= 1'b0;
            lives    <= LIVES_W'(INIT_LIVES_P);
            level    <= '0;
            shoot_q  <= 1'b1;
            fcnt_clr <= 1'b0;
        end else begin
            shoot_q  <= bus.shoot_i;
            add_life <= 1'b0;
            fcnt_clr <= 1'b0;
            unique case (state)
                ST_TITLE: begin
                    if (shoot_rise) begin
                        lives    <= LIVES_W'(INIT_LIVES_P);
                        level    <= '0;
                        state    <= ST_START;
                        outs     <= state_outs(ST_START);
                        fcnt_clr <= 1'b1;
                    end
                end
                ST_START: begin
                    if (t_done) begin
                        state    <= ST_PLAY;
                        outs     <= state_outs(ST_PLAY);
                        fcnt_clr <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Landing and a fatal hit both end the game and outrank a
                    // survivable hit, which in turn outranks clearing the wave.
                    if (bus.enemies_landed_i ||
                        (bus.player_hit_i && (lives == LIVES_W'(1)))) begin
                        lives    <= '0;
                        state    <= ST_LOSE;
                        outs     <= state_outs(ST_LOSE);
                        fcnt_clr <= 1'b1;
                    end else if (bus.player_hit_i) begin
                        lives    <= lives - LIVES_W'(1);
                        state    <= ST_HIT;
                        outs     <= state_outs(ST_HIT);
                        fcnt_clr <= 1'b1;
                    end else if (bus.enemies_dead_i) begin
                        state    <= ST_WIN;
                        outs     <= state_outs(ST_WIN);
                        fcnt_clr <= 1'b1;
                    end else if (pause_rise) begin
                        state    <= ST_PAUSED;
                        outs     <= state_outs(ST_PAUSED);
                        fcnt_clr <= 1'b1;
                    end
                end
                ST_HIT: begin
                    if (t_done) begin
                        state    <= ST_PLAY;
                        outs     <= state_outs(ST_PLAY);
                        fcnt_clr <= 1'b1;
                    end
                end
                ST_WIN: begin
                    if (t_done) begin
                        if (level != '1) begin
                            level <= level + LEVEL_W'(1);
                        end
                        if (lives < LIVES_W'(MAX_LIVES_P)) begin
                            lives    <= lives + LIVES_W'(1);
                            add_life <= 1'b1;
                        end
                        state    <= ST_START;
                        outs     <= state_outs(ST_START);
                        fcnt_clr <= 1'b1;
                    end
                end
                ST_LOSE: begin
                    // A press on the very frame the wait completes is accepted.
                    if (shoot_rise && (t_elapsed || t_done)) begin
                        lives    <= LIVES_W'(INIT_LIVES_P);
                        state    <= ST_TITLE;
                        outs     <= state_outs(ST_TITLE);
                        fcnt_clr <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (pause_rise) begin
                        state    <= ST_PLAY;
                        outs     <= state_outs(ST_PLAY);
                        fcnt_clr <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_TITLE;
                    outs     <= state_outs(ST_TITLE);
                    fcnt_clr <= 1'b1;
                end
            endcase
        end
    end

    assign bus.game_reset_o = outs.game_reset;
    assign bus.run_o        = outs.run;
    assign bus.screen_o     = outs.screen;
    assign bus.add_life_o   = add_life;
    assign bus.lives_o      = lives;
    assign bus.level_o      = level;
    assign bus.state_o      = state;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Self-checking bench for game_sequencer with default parameters. A table of
// stimulus records walks a full game; each record's expected outputs go into a
// scoreboard queue when it is applied and are popped and compared once the
// record's stimulus has completed. Reset and async-reset corners are
// hand-written. Optional GAME_PAUSE_EN rows are included when that macro is set.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    localparam logic [2:0] S_TITLE  = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_HIT    = 3'd3;
    localparam logic [2:0] S_WIN    = 3'd4;
    localparam logic [2:0] S_LOSE   = 3'd5;
    localparam logic [2:0] S_PAUSED = 3'd6;

    localparam int OP_EV = 0;
    localparam int OP_FR = 1;

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] screen;
        logic [2:0] lives;
        logic [3:0] level;
        logic       grst;
        logic       run;
        logic       add;
        logic [7:0] pulses;
    } exp_t;

    typedef struct {
        string name;
        int    op;
        bit    shoot;
        bit    hit;
        bit    landed;
        bit    dead;
        bit    pause;
        int    n;
        exp_t  exp;
    } rec_t;

    logic clk;
    logic rst_n;
    logic [7:0] pulses;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];
    rec_t tbl[$];

    game_sequencer_if bus();

    game_sequencer dut (
        .clk_i                  (clk),
        .reset_n_async_unsafe_i (rst_n),
        .bus                    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with add_life_o high; one per earned life means one-cycle pulses.
    always @(negedge clk) begin
        if (bus.add_life_o === 1'b1) pulses <= pulses + 8'd1;
    end

    function automatic exp_t mk_exp(logic [2:0] st, int lv, int lvl, int np);
        exp_t e;
        e.state  = st;
        e.lives  = 3'(lv);
        e.level  = 4'(lvl);
        e.add    = 1'b0;
        e.pulses = 8'(np);
        case (st)
            S_TITLE: begin e.screen = 2'd0; e.grst = 1'b1; e.run = 1'b0; end
            S_START: begin e.screen = 2'd1; e.grst = 1'b1; e.run = 1'b0; end
            S_PLAY:  begin e.screen = 2'd1; e.grst = 1'b0; e.run = 1'b1; end
            S_HIT:   begin e.screen = 2'd1; e.grst = 1'b0; e.run = 1'b0; end
            S_WIN:   begin e.screen = 2'd2; e.grst = 1'b0; e.run = 1'b0; end
            S_LOSE:  begin e.screen = 2'd3; e.grst = 1'b0; e.run = 1'b0; end
            default: begin e.screen = 2'd1; e.grst = 1'b0; e.run = 1'b0; end
        endcase
        return e;
    endfunction

    function automatic rec_t ev_rec(string name, bit s, bit h, bit l, bit d, bit p,
                                    logic [2:0] st, int lv, int lvl, int np);
        rec_t r;
        r.name = name; r.op = OP_EV; r.n = 0;
        r.shoot = s; r.hit = h; r.landed = l; r.dead = d; r.pause = p;
        r.exp = mk_exp(st, lv, lvl, np);
        return r;
    endfunction

    function automatic rec_t fr_rec(string name, int n, logic [2:0] st, int lv, int lvl, int np);
        rec_t r;
        r.name = name; r.op = OP_FR; r.n = n;
        r.shoot = 0; r.hit = 0; r.landed = 0; r.dead = 0; r.pause = 0;
        r.exp = mk_exp(st, lv, lvl, np);
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_frames(int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_i = 1'b1;
            cycle();
            bus.frame_i = 1'b0;
            cycle();
            cycle();
        end
    endtask

    task automatic do_event(bit s, bit h, bit l, bit d, bit p);
        bus.shoot_i          = s;
        bus.player_hit_i     = h;
        bus.enemies_landed_i = l;
        bus.enemies_dead_i   = d;
        bus.pause_i          = p;
        cycle();
        bus.shoot_i          = 1'b0;
        bus.player_hit_i     = 1'b0;
        bus.enemies_landed_i = 1'b0;
        bus.enemies_dead_i   = 1'b0;
        bus.pause_i          = 1'b0;
        cycle();
    endtask

    task automatic check_top(string name);
        exp_t e;
        exp_t a;
        #1;
        e = sb_q.pop_front();
        a.state  = bus.state_o;
        a.screen = bus.screen_o;
        a.lives  = bus.lives_o;
        a.level  = bus.level_o;
        a.grst   = bus.game_reset_o;
        a.run    = bus.run_o;
        a.add    = bus.add_life_o;
        a.pulses = pulses;
        n_checks++;
        if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got st=%0d scr=%0d lives=%0d lvl=%0d grst=%0b run=%0b add=%0b pulses=%0d; want st=%0d scr=%0d lives=%0d lvl=%0d grst=%0b run=%0b add=%0b pulses=%0d",
                     name, a.state, a.screen, a.lives, a.level, a.grst, a.run, a.add, a.pulses,
                     e.state, e.screen, e.lives, e.level, e.grst, e.run, e.add, e.pulses);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pulses   = 8'd0;
        rst_n    = 1'b1;
        bus.frame_i          = 1'b0;
        bus.shoot_i          = 1'b1;
        bus.pause_i          = 1'b0;
        bus.player_hit_i     = 1'b0;
        bus.enemies_landed_i = 1'b0;
        bus.enemies_dead_i   = 1'b0;

        // Full game walk: new game, three hits to game over, lose-screen lockout,
        // simultaneous landing/kill, two life-earning wins and one at the cap.
        tbl.push_back(ev_rec("new_game",        1,0,0,0,0, S_START, 3, 0, 0));
        tbl.push_back(fr_rec("start_29_frames", 29,        S_START, 3, 0, 0));
        tbl.push_back(fr_rec("start_30_frames", 1,         S_PLAY,  3, 0, 0));
        tbl.push_back(ev_rec("hit1",            0,1,0,0,0, S_HIT,   2, 0, 0));
        tbl.push_back(fr_rec("hit1_59_frames",  59,        S_HIT,   2, 0, 0));
        tbl.push_back(fr_rec("hit1_60_frames",  1,         S_PLAY,  2, 0, 0));
        tbl.push_back(ev_rec("hit2",            0,1,0,0,0, S_HIT,   1, 0, 0));
        tbl.push_back(fr_rec("hit2_done",       60,        S_PLAY,  1, 0, 0));
        tbl.push_back(ev_rec("hit3_last_life",  0,1,0,0,0, S_LOSE,  0, 0, 0));
        tbl.push_back(fr_rec("lose_10_frames",  10,        S_LOSE,  0, 0, 0));
        tbl.push_back(ev_rec("lose_shoot_early",1,0,0,0,0, S_LOSE,  0, 0, 0));
        tbl.push_back(fr_rec("lose_61_frames",  51,        S_LOSE,  0, 0, 0));
        tbl.push_back(ev_rec("lose_shoot_late", 1,0,0,0,0, S_TITLE, 3, 0, 0));
        tbl.push_back(ev_rec("new_game2",       1,0,0,0,0, S_START, 3, 0, 0));
        tbl.push_back(fr_rec("start2_done",     30,        S_PLAY,  3, 0, 0));
        tbl.push_back(ev_rec("landed_and_dead", 0,0,1,1,0, S_LOSE,  0, 0, 0));
        tbl.push_back(fr_rec("lose_60_frames",  60,        S_LOSE,  0, 0, 0));
        tbl.push_back(ev_rec("lose_shoot_at_60",1,0,0,0,0, S_TITLE, 3, 0, 0));
        tbl.push_back(ev_rec("new_game3",       1,0,0,0,0, S_START, 3, 0, 0));
        tbl.push_back(fr_rec("start3_done",     30,        S_PLAY,  3, 0, 0));
        tbl.push_back(ev_rec("wave1_cleared",   0,0,0,1,0, S_WIN,   3, 0, 0));
        tbl.push_back(fr_rec("win1_119_frames", 119,       S_WIN,   3, 0, 0));
        tbl.push_back(fr_rec("win1_done",       1,         S_START, 4, 1, 1));
        tbl.push_back(fr_rec("start4_done",     30,        S_PLAY,  4, 1, 1));
        tbl.push_back(ev_rec("wave2_cleared",   0,0,0,1,0, S_WIN,   4, 1, 1));
        tbl.push_back(fr_rec("win2_done",       120,       S_START, 5, 2, 2));
        tbl.push_back(fr_rec("start5_done",     30,        S_PLAY,  5, 2, 2));
        tbl.push_back(ev_rec("wave3_cleared",   0,0,0,1,0, S_WIN,   5, 2, 2));
        tbl.push_back(fr_rec("win3_at_max",     120,       S_START, 5, 3, 2));
        tbl.push_back(fr_rec("start6_done",     30,        S_PLAY,  5, 3, 2));
`ifdef GAME_PAUSE_EN
        tbl.push_back(ev_rec("pause_enter",     0,0,0,0,1, S_PAUSED, 5, 3, 2));
        tbl.push_back(ev_rec("paused_hit",      0,1,0,0,0, S_PAUSED, 5, 3, 2));
        tbl.push_back(fr_rec("paused_frames",   3,         S_PAUSED, 5, 3, 2));
        tbl.push_back(ev_rec("pause_exit",      0,0,0,0,1, S_PLAY,   5, 3, 2));
`endif
        tbl.push_back(ev_rec("hit_beats_dead",  0,1,0,1,0, S_HIT,   4, 3, 2));

        // Reset asserted with shoot already held.
        #2;
        rst_n = 1'b0;
        repeat (3) cycle();
        sb_q.push_back(mk_exp(S_TITLE, 3, 0, 0));
        check_top("reset_values");
        rst_n = 1'b1;
        repeat (3) cycle();
        sb_q.push_back(mk_exp(S_TITLE, 3, 0, 0));
        check_top("held_shoot_after_reset");
        bus.shoot_i = 1'b0;
        cycle();

        foreach (tbl[i]) begin
            sb_q.push_back(tbl[i].exp);
            if (tbl[i].op == OP_FR) begin
                do_frames(tbl[i].n);
            end else begin
                do_event(tbl[i].shoot, tbl[i].hit, tbl[i].landed, tbl[i].dead, tbl[i].pause);
            end
            check_top(tbl[i].name);
        end

        // Asynchronous reset in the middle of a HIT freeze, checked before any clock edge.
        do_frames(5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.push_back(mk_exp(S_TITLE, 3, 0, 2));
        check_top("async_reset_mid_hit");
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        sb_q.push_back(mk_exp(S_TITLE, 3, 0, 2));
        check_top("title_after_reset");
        sb_q.push_back(mk_exp(S_START, 3, 0, 2));
        do_event(1, 0, 0, 0, 0);
        check_top("new_game_after_reset");

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
